// File: rtl/anel_6bits_decoder_if.sv
// Bus between the 6-bit ring-phase decoder and its user: sample strobe and one-hot
// phase in, decoded index, status flags and revolution count out.
`timescale 1ns/1ps
interface anel_6bits_decoder_if #(
    parameter int unsigned REV_W = 8
);
    logic             enable;
    logic [5:0]       ring_in;
    logic [2:0]       index;
    logic             valid;
    logic             locked;
    logic             error;
    logic             wrap;
    logic [REV_W-1:0] rev_count;

    modport master (
        output enable, ring_in,
        input  index, valid, locked, error, wrap, rev_count
    );

    modport slave (
        input  enable, ring_in,
        output index, valid, locked, error, wrap, rev_count
    );
endinterface

// File: rtl/anel_6bits_decoder.sv
// Decodes a one-hot 6-phase ring vector to a binary index, tracks lock on
// consecutive forward steps and counts revolutions while locked.
`timescale 1ns/1ps
module anel_6bits_decoder #(
    parameter int unsigned LOCK_STEPS = 3,
    parameter int unsigned REV_W      = 8
) (
    input  logic                  clk,
    input  logic                  clear,
    anel_6bits_decoder_if.slave   bus
);
    localparam int unsigned STEP_W = 4;

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_LOCKING,
        ST_LOCKED,
        ST_FAULT
    } state_t;

    state_t            state_q;
    logic [STEP_W-1:0] step_cnt_q;
    logic [2:0]        index_q;
    logic              valid_q;
    logic              error_q;
    logic              wrap_q;
    logic [REV_W-1:0]  rev_count_q;

    logic              onehot_c;
    logic [2:0]        pos_c;
    logic [2:0]        succ_c;
    logic              correct_c;
    logic              lock_done_c;

    // One-hot detection and position of the set bit
    always_comb begin
        onehot_c = ($countones(bus.ring_in) == 1);
        pos_c    = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (bus.ring_in[i]) pos_c = 3'(i);
        end
    end

    assign succ_c      = (index_q == 3'd5) ? 3'd0 : index_q + 3'd1;
    assign correct_c   = onehot_c && (pos_c == succ_c);
    assign lock_done_c = ((5'(step_cnt_q) + 5'd1) == 5'(LOCK_STEPS));

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= ST_UNLOCKED;
            step_cnt_q  <= '0;
            index_q     <= 3'd0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            wrap_q      <= 1'b0;
            rev_count_q <= '0;
        end else begin
            wrap_q <= 1'b0;
            if (bus.enable) begin
                valid_q <= onehot_c;
                if (onehot_c) index_q <= pos_c;
                unique case (state_q)
                    ST_UNLOCKED: begin
                        if (onehot_c) begin
                            state_q    <= ST_LOCKING;
                            step_cnt_q <= '0;
                        end
                    end
                    ST_LOCKING: begin
                        if (correct_c) begin
                            step_cnt_q <= step_cnt_q + STEP_W'(1);
                            if (lock_done_c) state_q <= ST_LOCKED;
                        end else if (onehot_c) begin
                            step_cnt_q <= '0;
                        end else begin
                            state_q    <= ST_UNLOCKED;
                            step_cnt_q <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (correct_c) begin
                            // A forward step landing on phase 0 closes one revolution
                            if (pos_c == 3'd0) begin
                                rev_count_q <= rev_count_q + REV_W'(1);
                                wrap_q      <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_FAULT;
                            error_q <= 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        if (onehot_c) begin
                            state_q    <= ST_LOCKING;
                            step_cnt_q <= '0;
                        end
                    end
                    default: state_q <= ST_UNLOCKED;
                endcase
            end
        end
    end

    assign bus.index     = index_q;
    assign bus.valid     = valid_q;
    assign bus.locked    = (state_q == ST_LOCKED);
    assign bus.error     = error_q;
    assign bus.wrap      = wrap_q;
    assign bus.rev_count = rev_count_q;
endmodule
